// File: rtl/gf_mult_seq_if.sv
// Operand/product handshake bundle for the sequential GF(2^BYTE) multiplier.
// The master supplies operands and consumes products; the slave is the multiplier.
interface gf_mult_seq_if #(
    parameter int BYTE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [BYTE-1:0] in_a;
    logic [BYTE-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [BYTE-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/gf_mult_seq.sv
// Shift-and-add GF(2^BYTE) multiplier, one partial product per cycle, fixed BYTE-cycle run.
// Product is valid BYTE cycles after accept and held in DONE until consumed.
module gf_mult_seq #(
    parameter int              BYTE = 8,
    parameter logic [BYTE-1:0] POLY = 8'h1B
) (
    input logic         clk,
    input logic         rst,
    gf_mult_seq_if.slave bus
);
    localparam int CW = $clog2(BYTE) + 1;
    localparam logic [CW-1:0] LAST = CW'(BYTE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [BYTE-1:0] a_q;
    logic [BYTE-1:0] b_q;
    logic [BYTE-1:0] p_q;
    logic [CW-1:0]   cnt_q;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] v);
        logic [BYTE-1:0] sh;
        sh = {v[BYTE-2:0], 1'b0};
        return v[BYTE-1] ? (sh ^ POLY) : sh;
    endfunction

    // Handshake outputs come only from the state register, never from inputs.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = (state_q == DONE) ? p_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (cnt_q == LAST) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        p_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    // No early exit on b_q==0 so latency never depends on operands.
                    if (b_q[0]) p_q <= p_q ^ a_q;
                    b_q   <= b_q >> 1;
                    a_q   <= xtime(a_q);
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
